// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with single-cycle logic/arith ops, shift-add multiply and restoring divide
module alu_seq #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [3:0]   ALUControl,
    output logic         ready,
    output logic         done,
    output logic [N-1:0] result,
    output logic         zero,
    output logic         div0
);
    localparam int CW = $clog2(N + 1);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t       state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0] x_q, x_d, y_q, y_d, acc_q, acc_d, result_q, result_d;
    logic         rem_q, rem_d, div0_q, div0_d, qbit;
    logic [N:0]   r_sh, r_sub;
    logic [N-1:0] alu;
    logic         is_div;
    always_comb begin
        case (ALUControl)
            4'b0000: alu = a & b;
            4'b0001: alu = a | b;
            4'b0010: alu = a + b;
            4'b0110: alu = a - b;
            4'b1100: alu = ~(a | b);
            default: alu = b;
        endcase
    end
    assign is_div = (ALUControl == 4'b1001) || (ALUControl == 4'b1010);
    // x holds multiplicand or dividend/quotient, y multiplier or divisor, acc product or remainder
    assign r_sh  = {acc_q, x_q[N-1]};
    assign r_sub = r_sh - {1'b0, y_q};
    assign qbit  = ~r_sub[N];
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        acc_d    = acc_q;
        result_d = result_q;
        div0_d   = div0_q;
        rem_d    = rem_q;
        case (state_q)
            IDLE: if (start) begin
                div0_d = 1'b0;
                x_d    = a;
                y_d    = b;
                acc_d  = '0;
                cnt_d  = CW'(N);
                rem_d  = ALUControl == 4'b1010;
                if (ALUControl == 4'b1000) state_d = MUL;
                else if (is_div && b == '0) begin
                    result_d = rem_d ? a : '1;
                    div0_d   = 1'b1;
                    state_d  = DONE;
                end else if (is_div) state_d = DIV;
                else begin
                    result_d = alu;
                    state_d  = DONE;
                end
            end
            MUL: begin
                acc_d = acc_q + (y_q[0] ? x_q : '0);
                x_d   = x_q << 1;
                y_d   = y_q >> 1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_d == '0) begin
                    result_d = acc_d;
                    state_d  = DONE;
                end
            end
            DIV: begin
                acc_d = qbit ? r_sub[N-1:0] : r_sh[N-1:0];
                x_d   = {x_q[N-2:0], qbit};
                cnt_d = cnt_q - 1'b1;
                if (cnt_d == '0) begin
                    result_d = rem_q ? acc_d : x_d;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            div0_q   <= 1'b0;
            rem_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            div0_q   <= div0_d;
            rem_q    <= rem_d;
        end
    end
    assign ready  = state_q == IDLE;
    assign done   = state_q == DONE;
    assign result = result_q;
    assign zero   = result_q == '0;
    assign div0   = div0_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector table plus reset/abort sequences for alu_seq
module tb_alu_seq;
    localparam int N = 64;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [N-1:0] a = '0, b = '0;
    logic [3:0] ALUControl = '0;
    logic ready, done, zero, div0;
    logic [N-1:0] result;
    int total = 0, passed = 0;
    typedef struct {
        string       nm;
        logic [63:0] a, b;
        logic [3:0]  op;
        logic [63:0] r;
        logic        z, d0;
        int          lat;
    } vec_t;
    vec_t vt[20];
    alu_seq #(.N(N)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .ALUControl(ALUControl),
        .ready(ready), .done(done), .result(result), .zero(zero), .div0(div0)
    );
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask
    task automatic run(input vec_t v);
        int cyc;
        logic [63:0] hold;
        cyc = 0;
        while (!ready && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk({v.nm, " ready"}, 64'(ready), 64'd1);
        a = v.a;
        b = v.b;
        ALUControl = v.op;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        ALUControl = 4'($urandom);
        cyc = 1;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk({v.nm, " latency"}, done ? 64'(cyc) : 64'hDEAD, 64'(v.lat));
        chk({v.nm, " result"}, result, v.r);
        chk({v.nm, " zero"}, 64'(zero), 64'(v.z));
        chk({v.nm, " div0"}, 64'(div0), 64'(v.d0));
        hold = result;
        @(negedge clk);
        chk({v.nm, " done pulse"}, 64'(done), 64'd0);
        chk({v.nm, " ready after"}, 64'(ready), 64'd1);
        chk({v.nm, " held"}, result, hold);
    endtask
    initial begin
        int cyc;
        logic seen;
        vt[0]  = '{"add", 64'd5, 64'd7, 4'b0010, 64'd12, 1'b0, 1'b0, 1};
        vt[1]  = '{"sub eq", 64'd9, 64'd9, 4'b0110, 64'd0, 1'b1, 1'b0, 1};
        vt[2]  = '{"sub wrap", 64'd0, 64'd1, 4'b0110, ONES, 1'b0, 1'b0, 1};
        vt[3]  = '{"and", 64'hF0F0, 64'hFF00, 4'b0000, 64'hF000, 1'b0, 1'b0, 1};
        vt[4]  = '{"or", 64'hF0F0, 64'h0F0F, 4'b0001, 64'hFFFF, 1'b0, 1'b0, 1};
        vt[5]  = '{"passb", 64'd1, 64'h55, 4'b0111, 64'h55, 1'b0, 1'b0, 1};
        vt[6]  = '{"nor0", 64'd0, 64'd0, 4'b1100, ONES, 1'b0, 1'b0, 1};
        vt[7]  = '{"nor1", ONES, 64'd0, 4'b1100, 64'd0, 1'b1, 1'b0, 1};
        vt[8]  = '{"other", 64'd3, 64'd9, 4'b0011, 64'd9, 1'b0, 1'b0, 1};
        vt[9]  = '{"add ovf", ONES, 64'd1, 4'b0010, 64'd0, 1'b1, 1'b0, 1};
        vt[10] = '{"mul", 64'h1234, 64'h10, 4'b1000, 64'h12340, 1'b0, 1'b0, 65};
        vt[11] = '{"mul msb", 64'h8000_0000_0000_0000, 64'd2, 4'b1000, 64'd0, 1'b1, 1'b0, 65};
        vt[12] = '{"mul ones", ONES, ONES, 4'b1000, 64'd1, 1'b0, 1'b0, 65};
        vt[13] = '{"udiv", 64'd100, 64'd7, 4'b1001, 64'd14, 1'b0, 1'b0, 65};
        vt[14] = '{"urem", 64'd100, 64'd7, 4'b1010, 64'd2, 1'b0, 1'b0, 65};
        vt[15] = '{"udiv0", 64'd5, 64'd0, 4'b1001, ONES, 1'b0, 1'b1, 1};
        vt[16] = '{"urem0", 64'd5, 64'd0, 4'b1010, 64'd5, 1'b0, 1'b1, 1};
        vt[17] = '{"udiv big", ONES, 64'd1, 4'b1001, ONES, 1'b0, 1'b0, 65};
        vt[18] = '{"urem big", ONES, 64'h8000_0000_0000_0000, 4'b1010, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 65};
        vt[19] = '{"udiv small", 64'd7, 64'd100, 4'b1001, 64'd0, 1'b1, 1'b0, 65};
        #2;
        chk("rst ready", 64'(ready), 64'd1);
        chk("rst done", 64'(done), 64'd0);
        chk("rst result", result, 64'd0);
        chk("rst zero", 64'(zero), 64'd1);
        chk("rst div0", 64'(div0), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) run(vt[i]);
        // div0 left set by a divide-by-zero clears as soon as the next op is accepted
        run(vt[15]);
        a = 64'd3;
        b = 64'd5;
        ALUControl = 4'b1000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("div0 clear", 64'(div0), 64'd0);
        chk("busy", 64'(ready), 64'd0);
        cyc = 1;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("mul after div0", result, 64'd15);
        @(negedge clk);
        a = 64'd3;
        b = 64'd5;
        ALUControl = 4'b1000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (c >= 3 && c <= 5) begin
                start = 1'b1;
                a = 64'd1;
                b = 64'd1;
                ALUControl = 4'b0010;
            end else start = 1'b0;
            @(negedge clk);
            seen = seen | done;
        end
        start = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("abort no done", 64'(seen), 64'd0);
        chk("abort result", result, 64'd0);
        chk("abort ready", 64'(ready), 64'd1);
        chk("abort zero", 64'(zero), 64'd1);
        chk("abort done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        run('{"add after rst", 64'd1, 64'd1, 4'b0010, 64'd2, 1'b0, 1'b0, 1});
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter N, default 64: operand and result width in bits; the SHALL be legal for any N >= 4.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset; SHALL act immediately, independent of clk.
REQ-004 start  input  1  request strobe; SHALL be accepted only on a rising edge where ready=1.
REQ-005 a  input  N  first operand, sampled at accept.
REQ-006 b  input  N  second operand, sampled at accept.
REQ-007 ALUControl  input  4  operation select, sampled at accept.
REQ-008 ready  output  1  high when idle and able to accept start.
REQ-009 done  output  1  one-cycle pulse marking result valid.
REQ-010 result  output  N  registered result; held from done until the next accept.
REQ-011 zero  output  1  SHALL be 1 exactly when result == 0 (all N bits compared).
REQ-012 div0  output  1  SHALL be 1 with done when a UDIV/UREM had b == 0; held with result.

Function
REQ-013 Operation codes SHALL be:
- 0000 a AND b
- 0001 a OR b
- 0010 a+b mod 2^N
- 0110 a-b mod 2^N
- 0111 b
- 1100 NOR(a,b)
- 1000 MUL, low N bits of unsigned a*b
- 1001 UDIV, unsigned quotient
- 1010 UREM, unsigned remainder
- any other code: b
REQ-014 FSM states SHALL be IDLE, MUL, DIV, DONE; ready=1 only in IDLE.
REQ-015 IDLE + start with a single-cycle op (all codes except 1000/1001/1010) SHALL compute and register result and go to DONE on that edge.
REQ-016 IDLE + start with 1000 SHALL latch operands, clear the accumulator, load a counter with N and go to MUL.
REQ-017 MUL: each cycle SHALL add multiplicand to accumulator when multiplier LSB=1, shift multiplicand left 1, shift multiplier right 1, decrement counter; reaching 0 SHALL go to DONE with accumulator as result.
REQ-018 IDLE + start with 1001/1010 and b != 0 SHALL go to DIV with counter N; restoring division SHALL produce one quotient bit per cycle, MSB first; at counter 0 SHALL go to DONE.
REQ-019 UDIV/UREM with b == 0 SHALL go straight to DONE: result all-ones (UDIV) or a (UREM), div0=1.
REQ-020 DONE SHALL last exactly one cycle with done=1 and SHALL return to IDLE.
REQ-021 Latency from accept edge to done: 1 cycle for single-cycle ops and divide-by-zero; N+1 cycles for MUL and UDIV/UREM with b != 0.
REQ-022 start while ready=0 SHALL be ignored with no queuing; a, b, ALUControl changes after accept SHALL NOT affect the operation.
REQ-023 result, zero and div0 SHALL remain stable from the done cycle until the next accepted start; div0 SHALL clear on the next accept.
REQ-024 All intermediate registers SHALL be internal; no combinational path from a/b/ALUControl to result or zero.

Reset
REQ-025 While reset=1, all state SHALL be forced: state=IDLE, counter=0, result=0, done=0, div0=0; outputs ready=1, zero=1.
REQ-026 Reset asserted mid-MUL or mid-DIV SHALL abandon the operation with no done pulse.
REQ-027 After reset release, the first edge with start=1 SHALL be accepted.

Verification (N=64)
REQ-028 ADD a=5, b=7 -> done exactly 1 cycle after accept, result=12, zero=0, ready back to 1 on the following cycle.
REQ-029 SUB a=9, b=9 -> result=0, zero=1; SUB a=0, b=1 -> result=0xFFFF_FFFF_FFFF_FFFF.
REQ-030 MUL a=0x1234, b=0x10 -> done at cycle 65 after accept, result=0x12340; MUL a=2^63, b=2 -> result=0, zero=1.
REQ-031 UDIV a=100, b=7 -> result=14 at cycle 65; UREM a=100, b=7 -> result=2; UDIV a=5, b=0 -> result all-ones and div0=1 after 1 cycle.
REQ-032 MUL started, start re-pulsed at cycles 3-5 with new operands, reset asserted at cycle 10 -> no done pulse; result=0, ready=1, zero=1 immediately; next ADD 1+1 -> result=2.
